// File: rtl/toggle_activity_monitor.sv
// Per-net toggle counter over a fixed window of enabled cycles. At each window end the
// counts are snapshotted into a shadow bank and streamed out one record per net over a
// valid/ready port. Windows that end while a stream is in progress are dropped and flagged.
module toggle_activity_monitor #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned IDX_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] NETS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [IDX_W-1:0] OUT_IDX,
    output logic [CNT_W-1:0] OUT_COUNT,
    output logic             OVERFLOW
);

    localparam int unsigned      WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic             primed_q;
    logic [CNT_W-1:0] live_q   [WIDTH];
    logic [CNT_W-1:0] live_nxt [WIDTH];
    logic [CNT_W-1:0] shadow_q [WIDTH];
    logic [WIN_W-1:0] win_cnt_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic             overflow_q;

    logic win_end;
    logic handshake;
    logic last_handshake;

    assign win_end        = EN && (win_cnt_q == WIN_LAST);
    assign handshake      = (state_q == StStream) && OUT_READY;
    assign last_handshake = handshake && (rd_idx_q == IDX_LAST);

    // Live counts including this cycle's toggles, saturating at the counter maximum.
    always_comb begin
        live_nxt = live_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (EN && primed_q && (NETS[i] != prev_q[i]) && (live_q[i] != CNT_MAX)) begin
                live_nxt[i] = live_q[i] + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a window end only starts a stream when idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (win_end) state_d = StStream;
            StStream: if (last_handshake) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: the record is a pure function of registered state, so it holds under stall.
    always_comb begin
        OUT_VALID = (state_q == StStream);
        OUT_IDX   = rd_idx_q;
        OUT_COUNT = '0;
        if (state_q == StStream) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (rd_idx_q == IDX_W'(i)) OUT_COUNT = shadow_q[i];
            end
        end
        OVERFLOW = overflow_q;
    end

    // Sampling, window counting, snapshot and read pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            win_cnt_q  <= '0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (EN) begin
                prev_q    <= NETS;
                primed_q  <= 1'b1;
                win_cnt_q <= win_end ? '0 : win_cnt_q + WIN_W'(1);
            end

            for (int unsigned i = 0; i < WIDTH; i++) begin
                live_q[i] <= win_end ? '0 : live_nxt[i];
            end

            if (win_end && (state_q == StIdle)) begin
                shadow_q <= live_nxt;
            end

            // A window ending mid-stream is discarded; the old snapshot keeps streaming.
            if (win_end && (state_q == StStream)) begin
                overflow_q <= 1'b1;
            end

            if (win_end && (state_q == StIdle)) begin
                rd_idx_q <= '0;
            end else if (handshake) begin
                rd_idx_q <= last_handshake ? '0 : rd_idx_q + IDX_W'(1);
            end
        end
    end

endmodule
